// File: rtl/uart_apb_transmitter.sv
// UART transmitter with an APB slave front end.
//
// The CPU writes a data word to ADDR_UART over APB. The word lands in a
// one-entry holding register and is serialised onto txOutput using the
// shared 16x baud tick. The frame is a start bit, DATA_BITS data bits sent
// LSB first, and a stop bit of SB_TICK ticks. A read of the same address
// returns status {hold_full, txBusy}.
//
// Ports:
//   clk, reset_n           clock (rising edge), async active-low reset
//   s_tick                 one-cycle pulse at 16x baud rate
//   psel, penable, pwrite  APB control
//   paddr, pwdata          APB address / write data (pwdata[DATA_BITS-1:0] used)
//   prdata, pready, pslverr  APB response (combinational, access phase only)
//   txOutput               serial line, registered, idles high
//   txBusy                 high while a frame is in progress
//   txDoneTick             one-cycle pulse on the final stop-bit tick
module uart_apb_transmitter #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned SB_TICK   = 16,
  parameter logic [31:0] ADDR_UART = 32'h2364
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_tick,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        txOutput,
  output logic        txBusy,
  output logic        txDoneTick
);

  localparam int unsigned S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int unsigned N_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [S_W-1:0] S_LAST    = S_W'(15);
  localparam logic [S_W-1:0] STOP_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST    = N_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_next;
  logic [S_W-1:0]       s_reg, s_next;
  logic [N_W-1:0]       n_reg, n_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] hold_reg;
  logic                 hold_full;
  logic                 hold_load, hold_drain;
  logic                 tx_reg, tx_next;
  logic                 access, addr_hit;
  logic                 unused_pwdata;

  assign access    = psel & penable;
  assign addr_hit  = (paddr == ADDR_UART);
  assign hold_load = access & addr_hit & pwrite & ~hold_full;

  // Upper write-data bits beyond DATA_BITS are ignored.
  assign unused_pwdata = ^(pwdata >> DATA_BITS);

  assign txBusy   = (state != IDLE);
  assign txOutput = tx_reg;

  // APB response
  always_comb begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    if (access) begin
      if (!addr_hit) begin
        pready  = 1'b1;
        pslverr = 1'b1;
      end else if (pwrite) begin
        pready = ~hold_full;
      end else begin
        pready = 1'b1;
        prdata = {30'b0, hold_full, txBusy};
      end
    end
  end

  // Holding register: load and drain are mutually exclusive since a load
  // needs hold_full=0 and a drain needs hold_full=1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
    end else if (hold_load) begin
      hold_reg  <= pwdata[DATA_BITS-1:0];
      hold_full <= 1'b1;
    end else if (hold_drain) begin
      hold_full <= 1'b0;
    end
  end

  // Transmit FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state     <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s_reg;
    n_next     = n_reg;
    shift_next = shift_reg;
    hold_drain = 1'b0;
    txDoneTick = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          hold_drain = 1'b1;
          shift_next = hold_reg;
          s_next     = '0;
          state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_reg == S_LAST) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == S_LAST) begin
            s_next     = '0;
            shift_next = shift_reg >> 1;
            if (n_reg == N_LAST) state_next = STOP;
            else                 n_next     = n_reg + 1'b1;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_reg == STOP_LAST) begin
            txDoneTick = 1'b1;
            state_next = IDLE;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is decoded from the next state so the registered output
    // changes on the same edge as the state, with no extra cycle of lag.
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_apb_transmitter.sv
module tb_uart_apb_transmitter;

  localparam logic [31:0] ADDR = 32'h2364;
  localparam int DB0 = 8;
  localparam int SB0 = 16;
  localparam int DB1 = 7;
  localparam int SB1 = 32;

  typedef struct packed {
    logic [31:0] data;
    logic        chk_gap;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        s_tick = 1'b0;
  logic [1:0]  tdiv = '0;
  logic        psel0 = 1'b0, psel1 = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;

  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1, pslverr0, pslverr1;
  logic        txo0, txo1, busy0, busy1, done0, done1;

  int vectors = 0;
  int miscompares = 0;
  exp_t q0[$];
  exp_t q1[$];

  // monitor state per DUT
  int          tck[2];
  logic        infr[2];
  int          serr[2];
  int          gapc[2];
  int          startgap[2];
  exp_t        cur[2];
  logic        have[2];
  int          frames[2];
  logic [31:0] rxw[2];

  uart_apb_transmitter #(.DATA_BITS(DB0), .SB_TICK(SB0), .ADDR_UART(ADDR)) dut0 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick),
    .psel(psel0), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
    .txOutput(txo0), .txBusy(busy0), .txDoneTick(done0)
  );

  uart_apb_transmitter #(.DATA_BITS(DB1), .SB_TICK(SB1), .ADDR_UART(ADDR)) dut1 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick),
    .psel(psel1), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata1), .pready(pready1), .pslverr(pslverr1),
    .txOutput(txo1), .txBusy(busy1), .txDoneTick(done1)
  );

  always #5 clk = ~clk;

  // 16x tick: one cycle in every four
  always @(posedge clk) begin
    tdiv   <= tdiv + 2'd1;
    s_tick <= (tdiv == 2'd3);
  end

  function automatic logic tx_of(input int k);    return (k == 0) ? txo0 : txo1;         endfunction
  function automatic logic done_of(input int k);  return (k == 0) ? done0 : done1;       endfunction
  function automatic logic busy_of(input int k);  return (k == 0) ? busy0 : busy1;       endfunction
  function automatic logic ready_of(input int k); return (k == 0) ? pready0 : pready1;   endfunction
  function automatic logic err_of(input int k);   return (k == 0) ? pslverr0 : pslverr1; endfunction
  function automatic logic [31:0] rdata_of(input int k); return (k == 0) ? prdata0 : prdata1; endfunction
  function automatic int db_of(input int k);      return (k == 0) ? DB0 : DB1;           endfunction
  function automatic int sb_of(input int k);      return (k == 0) ? SB0 : SB1;           endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  // One APB transfer; an accepted write to ADDR is pushed to the scoreboard.
  task automatic apb(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err, output int waits);
    exp_t e;
    logic ok;
    @(posedge clk); #1;
    if (k == 0) psel0 = 1'b1; else psel1 = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    ok = 1'b0;
    while (!ok) begin
      @(negedge clk);
      if (ready_of(k)) ok = 1'b1;
      else begin
        waits++;
        if (waits >= 20000) begin
          vectors++; miscompares++;
          $display("FAIL apb_timeout dut%0d: got no pready after %0d cycles, required pready=1", k, waits);
          ok = 1'b1;
        end
      end
    end
    rd  = rdata_of(k);
    err = err_of(k);
    if (wr && ready_of(k) && !err && a == ADDR) begin
      e.data    = d & ((32'h1 << db_of(k)) - 32'h1);
      e.chk_gap = busy_of(k);
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk); #1;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || infr[0] || infr[1]) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: got %0d/%0d pending frames, required 0", q0.size(), q1.size());
    end
  endtask

  // Line monitor: frame expectation = 16 ticks low, each data bit for 16
  // ticks LSB first, SB_TICK ticks high, done pulse on the last stop tick.
  task automatic mon_step(input int k);
    int   db, total, t;
    logic ln, dn, bz, expb;
    db    = db_of(k);
    total = 16 + 16 * db + sb_of(k);
    ln = tx_of(k); dn = done_of(k); bz = busy_of(k);
    if (!reset_n) begin
      infr[k] = 1'b0;
      gapc[k] = -1;
      return;
    end
    if (!infr[k]) begin
      if (ln == 1'b0) begin
        infr[k] = 1'b1; tck[k] = 0; serr[k] = 0; rxw[k] = '0;
        startgap[k] = gapc[k];
        frames[k]++;
        have[k] = (k == 0) ? (q0.size() != 0) : (q1.size() != 0);
        if (have[k]) cur[k] = (k == 0) ? q0.pop_front() : q1.pop_front();
        else begin
          cur[k] = '0;
          vectors++; miscompares++;
          $display("FAIL unexpected_frame dut%0d: got a start bit, required idle line", k);
        end
      end else begin
        if (dn || bz) begin
          vectors++; miscompares++;
          $display("FAIL idle_outputs dut%0d: got done=%b busy=%b, required 0 0", k, dn, bz);
        end
        if (gapc[k] >= 0) gapc[k]++;
      end
    end
    if (infr[k]) begin
      t = tck[k];
      if (t < 16) expb = 1'b0;
      else if (t < 16 + 16 * db) expb = cur[k].data[(t - 16) / 16];
      else expb = 1'b1;
      if (ln !== expb) serr[k]++;
      if (!bz) serr[k]++;
      if (t >= 16 && t < 16 + 16 * db && (t - 16) % 16 == 8) rxw[k][(t - 16) / 16] = ln;
      if (s_tick) begin
        if (dn !== (t == total - 1)) serr[k]++;
        tck[k]++;
        if (t == total - 1) begin
          infr[k] = 1'b0;
          gapc[k] = 0;
          if (have[k]) begin
            vectors++;
            if (serr[k] != 0 || rxw[k] !== cur[k].data || (cur[k].chk_gap && startgap[k] != 1)) begin
              miscompares++;
              $display("FAIL frame dut%0d: got word %h (line errors %0d, idle gap %0d), required word %h (gap check %0d)",
                       k, rxw[k], serr[k], startgap[k], cur[k].data, cur[k].chk_gap);
            end
          end
        end
      end else if (dn) begin
        serr[k]++;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      infr[k] = 1'b0; gapc[k] = -1; frames[k] = 0; tck[k] = 0; serr[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) mon_step(k);
    end
  end

  initial begin
    logic [31:0] rd, a, d;
    logic        err;
    int          w, snap, k, kind;

    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx0", 32'(txo0), 32'd1);
    chk("reset_busy0", 32'(busy0), 32'd0);
    chk("reset_pready0", 32'(pready0), 32'd0);
    chk("reset_tx1", 32'(txo1), 32'd1);
    chk("reset_busy1", 32'(busy1), 32'd0);
    chk("reset_pready1", 32'(pready1), 32'd0);
    reset_n = 1'b1;

    apb(0, 1'b0, ADDR, 32'h0, rd, err, w);
    chk("reset_status", rd, 32'h0);
    chk("reset_status_err", 32'(err), 32'd0);

    // single frame
    apb(0, 1'b1, ADDR, 32'h0000_00A5, rd, err, w);
    chk("a5_waits", 32'(w), 32'd0);
    wait_drain();
    apb(0, 1'b0, ADDR, 32'h0, rd, err, w);
    chk("a5_status_after", rd, 32'h0);

    // back-to-back frames
    apb(0, 1'b1, ADDR, 32'h0000_003C, rd, err, w);
    chk("b2b_first_waits", 32'(w), 32'd0);
    apb(0, 1'b1, ADDR, 32'h0000_00C3, rd, err, w);
    chk("b2b_second_waits", 32'(w), 32'd0);
    apb(0, 1'b1, ADDR, 32'h0000_00FF, rd, err, w);
    chk("b2b_third_stalls", 32'(w > 0), 32'd1);
    wait_drain();

    // bad address
    apb(0, 1'b1, 32'h0000_1000, 32'h0000_0077, rd, err, w);
    chk("bad_wr_err", 32'(err), 32'd1);
    chk("bad_wr_waits", 32'(w), 32'd0);
    apb(0, 1'b0, 32'h0000_1000, 32'h0, rd, err, w);
    chk("bad_rd_err", 32'(err), 32'd1);
    chk("bad_rd_data", rd, 32'h0);
    apb(0, 1'b0, ADDR, 32'h0, rd, err, w);
    chk("bad_status", rd, 32'h0);
    chk("bad_line", 32'(txo0), 32'd1);

    // reset mid-frame with a word pending
    apb(0, 1'b1, ADDR, 32'h0000_0055, rd, err, w);
    apb(0, 1'b1, ADDR, 32'h0000_00AA, rd, err, w);
    apb(0, 1'b0, ADDR, 32'h0, rd, err, w);
    chk("midframe_status", rd, 32'h3);
    repeat (120) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midreset_tx", 32'(txo0), 32'd1);
    chk("midreset_busy", 32'(busy0), 32'd0);
    q0.delete(); q1.delete();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    snap = frames[0];
    apb(0, 1'b0, ADDR, 32'h0, rd, err, w);
    chk("postreset_status", rd, 32'h0);
    repeat (600) @(posedge clk);
    chk("postreset_no_frame", 32'(frames[0]), 32'(snap));

    // 7 data bits, 2 stop bits; upper write bits must be ignored
    apb(1, 1'b1, ADDR, 32'hFFFF_FFC1, rd, err, w);
    apb(1, 1'b0, ADDR, 32'h0, rd, err, w);
    chk("db7_status_during", rd, 32'h1);
    wait_drain();

    // randomized traffic
    for (int i = 0; i < 24; i++) begin
      k    = ($urandom_range(0, 3) == 0) ? 1 : 0;
      kind = $urandom_range(0, 5);
      d    = $urandom;
      if (kind == 0) begin
        a = $urandom;
        if (a == ADDR) a = a ^ 32'h1;
        apb(k, d[0], a, d, rd, err, w);
        chk("rand_bad_err", 32'(err), 32'd1);
        chk("rand_bad_data", rd, 32'h0);
      end else begin
        apb(k, 1'b1, ADDR, d, rd, err, w);
      end
      repeat ($urandom_range(0, 700)) @(posedge clk);
    end
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
